// File: rtl/dp_issue.sv
// Issue stage for the ARM7 data-processing ALU: condition check, classification, timed ALU issue.
// Latency: accept to retire is 3 cycles (skipped/undef) or 3+EN_HOLD+ALU_LATENCY cycles (issued).
// Backpressure: instr_ready is high only in IDLE; one instruction in flight, no back-to-back accepts.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr_valid/instr_ready/instr   instruction handshake and 32-bit word
//   cpsr_read_en/cpsr_read_value    CPSR read request; value returns the following cycle
//   alu_en, alu_immediate, alu_opcode, alu_s, alu_rn, alu_rd, alu_operand2   ALU issue fields
//   retire_valid, retire_skipped, retire_undef                              retire pulse and qualifiers
module dp_issue #(
    parameter int EN_HOLD     = 2,
    parameter int ALU_LATENCY = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic        cpsr_read_en,
    input  logic [31:0] cpsr_read_value,
    output logic        alu_en,
    output logic        alu_immediate,
    output logic [3:0]  alu_opcode,
    output logic        alu_s,
    output logic [3:0]  alu_rn,
    output logic [3:0]  alu_rd,
    output logic [11:0] alu_operand2,
    output logic        retire_valid,
    output logic        retire_skipped,
    output logic        retire_undef
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CPSR_REQ,
        S_EVAL,
        S_ISSUE,
        S_WAIT,
        S_RETIRE
    } state_t;

    // Counters are loaded with (N-1) so that a state lasts exactly N cycles.
    localparam logic [7:0] EN_LOAD  = 8'(EN_HOLD - 1);
    localparam logic [7:0] LAT_LOAD = 8'(ALU_LATENCY - 1);

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        skip_q, skip_d;
    logic        undef_q, undef_d;

    logic        is_dp;
    logic        cond_ok;
    logic        fields_vld;

    // Only the flag nibble of CPSR matters here.
    logic        unused_cpsr_bits;
    assign unused_cpsr_bits = ^cpsr_read_value[27:0];

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c & !z;
            4'h9:    r = !c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Multiply and extra load/store share the 00 class but have bit7 and bit4 set with I=0.
    assign is_dp   = (instr_q[27:26] == 2'b00) &&
                     !(!instr_q[25] && instr_q[7] && instr_q[4]);
    assign cond_ok = cond_pass(instr_q[31:28], cpsr_read_value[31:28]);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        undef_d = undef_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    skip_d  = 1'b0;
                    undef_d = 1'b0;
                    state_d = S_CPSR_REQ;
                end
            end
            S_CPSR_REQ: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                if (!is_dp || instr_q[31:28] == 4'hF) begin
                    undef_d = 1'b1;
                    state_d = S_RETIRE;
                end else if (!cond_ok) begin
                    skip_d  = 1'b1;
                    state_d = S_RETIRE;
                end else begin
                    cnt_d   = EN_LOAD;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = LAT_LOAD;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_RETIRE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RETIRE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            cnt_q   <= '0;
            skip_q  <= 1'b0;
            undef_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            undef_q <= undef_d;
        end
    end

    // ALU fields are held from ISSUE entry through the retire cycle of an issued instruction.
    assign fields_vld = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                        ((state_q == S_RETIRE) && !skip_q && !undef_q);

    assign instr_ready    = (state_q == S_IDLE);
    assign cpsr_read_en   = (state_q == S_CPSR_REQ);
    assign alu_en         = (state_q == S_ISSUE);
    assign alu_immediate  = fields_vld ? instr_q[25]    : 1'b0;
    assign alu_opcode     = fields_vld ? instr_q[24:21] : 4'h0;
    assign alu_s          = fields_vld ? instr_q[20]    : 1'b0;
    assign alu_rn         = fields_vld ? instr_q[19:16] : 4'h0;
    assign alu_rd         = fields_vld ? instr_q[15:12] : 4'h0;
    assign alu_operand2   = fields_vld ? instr_q[11:0]  : 12'h000;
    assign retire_valid   = (state_q == S_RETIRE);
    assign retire_skipped = retire_valid && skip_q;
    assign retire_undef   = retire_valid && undef_q;

endmodule

// File: doc/dp_issue.md
Name: dp_issue

Overview:
- Upstream issue stage for the ARM7 data-processing ALU.
- Accepts one 32-bit instruction word at a time over a valid/ready handshake and reads CPSR from the register file.
- Evaluates the condition field and classifies the instruction as data-processing or not.
- For a passing data-processing instruction, drives the ALU's en/immediate/opcode/s/rn/rd/operand2 inputs for a fixed hold window, then waits a fixed ALU latency before retiring and accepting the next instruction.

Parameters:
- EN_HOLD, 2, cycles alu_en is held high per issue (1..15).
- ALU_LATENCY, 40, cycles waited after alu_en drops before retire (1..255).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instr holds a valid instruction
- instr_ready  output  1  block can accept an instruction
- instr  input  32  ARM instruction word
- cpsr_read_en  output  1  CPSR read request to register file
- cpsr_read_value  input  32  CPSR; valid the cycle after cpsr_read_en
- alu_en  output  1  ALU start
- alu_immediate  output  1  instr[25]
- alu_opcode  output  4  instr[24:21]
- alu_s  output  1  instr[20]
- alu_rn  output  4  instr[19:16]
- alu_rd  output  4  instr[15:12]
- alu_operand2  output  12  instr[11:0]
- retire_valid  output  1  one-cycle pulse, instruction finished
- retire_skipped  output  1  qualifies retire_valid: condition failed
- retire_undef  output  1  qualifies retire_valid: not data-processing, or cond=1111

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0 except instr_ready=1; the latched instruction and counters are cleared. Reset mid-operation aborts immediately; no retire is produced.
- State IDLE: instr_ready=1. On instr_valid & instr_ready, latch instr and go to CPSR_REQ. instr_ready=0 in every other state; no back-to-back accepts.
- State CPSR_REQ (1 cycle): cpsr_read_en=1. Go to EVAL.
- State EVAL (1 cycle): sample cpsr_read_value: N=[31], Z=[30], C=[29], V=[28]. Evaluate cond=instr[31:28]:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1
  - 1111: undef.
- Classification: data-processing iff instr[27:26]==00 and not (instr[25]==0 & instr[7]==1 & instr[4]==1). Multiply and extra load/store are undef.
- Priority in EVAL: undef, then cond-fail, then issue.
  - undef → RETIRE with retire_undef=1.
  - Cond fail → RETIRE with retire_skipped=1.
  - Otherwise → ISSUE.
- State ISSUE: alu_en=1 for exactly EN_HOLD cycles, then WAIT.
  - alu_immediate/opcode/s/rn/rd/operand2 are driven from the latched instruction and stay stable from ISSUE entry until RETIRE ends.
  - They are 0 in IDLE.
- State WAIT: alu_en=0 for exactly ALU_LATENCY cycles (down-counter loaded on entry), then RETIRE.
- State RETIRE (1 cycle): retire_valid=1 with its qualifiers, then IDLE.
  - Qualifiers are 0 whenever retire_valid=0.
  - retire_skipped and retire_undef are never both 1.
- Latency from the accept edge to the retire_valid cycle:
  - Issued instruction: 2+EN_HOLD+ALU_LATENCY+1 cycles (default 45).
  - Skipped or undef instruction: 3 cycles.
- instr changing while not accepted is ignored. instr_valid deasserting after accept has no effect.
- CPSR is sampled only in EVAL. Flag changes after EVAL do not affect the in-flight instruction.

Test Plan:
1. ADD r0,r1,r2 (instr=0xE0810002), CPSR=0 → alu_en high 2 cycles with opcode=0100, rn=1, rd=0, operand2=0x002, immediate=0; retire_valid 45 cycles after accept, skipped=0, undef=0; register file r0=12 when r1=5, r2=7.
2. MOVEQ r9,#0x123 (0x03A09123) with CPSR Z=0 → no alu_en; retire_valid 3 cycles after accept with retire_skipped=1. Repeat with Z=1 → alu_en issued, immediate=1, opcode=1101, rd=9, operand2=0x123.
3. Condition sweep: each cond 0000..1110 against CPSR NZCV = 0000, 0100, 0010, 1001, 1000 → skipped matches the table above in all 75 cases.
4. MUL (0xE0000291) and LDR (0xE5910000) → retire_undef=1, no alu_en. cond=1111 with a DP encoding → retire_undef=1.
5. Handshake: instr_valid held high with two different instructions queued → instr_ready=0 from accept until retire+1; second instruction accepted only in IDLE; exactly one retire per accept.
6. Assert rst_n=0 during WAIT → all outputs 0 immediately, instr_ready=1 after release, no retire pulse; the next ADD completes normally.
